// File: rtl/attack_sequencer.sv
// rtl/attack_sequencer.sv - per-player attack timing FSM: startup, one-clk strike, recovery, hit-stun.
// All outputs decode registered state only; presses are rising edges of the debounced levels.
module attack_sequencer #(
  parameter int LIGHT_STARTUP  = 3,
  parameter int LIGHT_RECOVERY = 8,
  parameter int HEAVY_STARTUP  = 6,
  parameter int HEAVY_RECOVERY = 16,
  parameter int STUN_FRAMES    = 10,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_light,
  input  logic       btn_heavy,
  input  logic [2:0] game_state,
  input  logic       hit_taken,
  output logic [1:0] attack_state,
  output logic       busy,
  output logic       stunned,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STARTUP  = 3'd1,
    S_ACTIVE   = 3'd2,
    S_RECOVERY = 3'd3,
    S_STUN     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LS_M1   = CNT_W'(LIGHT_STARTUP - 1);
  localparam logic [CNT_W-1:0] LR_M1   = CNT_W'(LIGHT_RECOVERY - 1);
  localparam logic [CNT_W-1:0] HS_M1   = CNT_W'(HEAVY_STARTUP - 1);
  localparam logic [CNT_W-1:0] HR_M1   = CNT_W'(HEAVY_RECOVERY - 1);
  localparam logic [CNT_W-1:0] STUN_M1 = CNT_W'(STUN_FRAMES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             type_heavy_q, type_heavy_d;
  logic             buf_valid_q, buf_valid_d;
  logic             buf_heavy_q, buf_heavy_d;
  logic             light_prev_q, heavy_prev_q;

  logic light_rise, heavy_rise, press;
  logic buf_valid_m, buf_heavy_m;
  logic cnt_zero;

  assign light_rise = btn_light & ~light_prev_q;
  assign heavy_rise = btn_heavy & ~heavy_prev_q;
  assign press      = light_rise | heavy_rise;
  assign cnt_zero   = (cnt_q == '0);

  // Buffer merge: heavy overwrites light, a light press never downgrades a held heavy.
  assign buf_valid_m = buf_valid_q | press;
  assign buf_heavy_m = (buf_valid_q & buf_heavy_q) | heavy_rise;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    type_heavy_d = type_heavy_q;
    buf_valid_d  = buf_valid_q;
    buf_heavy_d  = buf_heavy_q;

    if (game_state != 3'b000) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      buf_valid_d = 1'b0;
      buf_heavy_d = 1'b0;
    end else if (hit_taken) begin
      state_d     = S_STUN;
      cnt_d       = STUN_M1;
      buf_valid_d = 1'b0;
      buf_heavy_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (press) begin
            type_heavy_d = heavy_rise;
            cnt_d        = heavy_rise ? HS_M1 : LS_M1;
            state_d      = S_STARTUP;
          end
        end
        S_STARTUP: begin
          buf_valid_d = buf_valid_m;
          buf_heavy_d = buf_heavy_m;
          if (frame_tick) begin
            if (cnt_zero) state_d = S_ACTIVE;
            else          cnt_d   = cnt_q - 1'b1;
          end
        end
        S_ACTIVE: begin
          buf_valid_d = buf_valid_m;
          buf_heavy_d = buf_heavy_m;
          cnt_d       = type_heavy_q ? HR_M1 : LR_M1;
          state_d     = S_RECOVERY;
        end
        S_RECOVERY: begin
          buf_valid_d = buf_valid_m;
          buf_heavy_d = buf_heavy_m;
          if (frame_tick) begin
            if (!cnt_zero) begin
              cnt_d = cnt_q - 1'b1;
            end else if (buf_valid_m) begin
              // Chained attack: launch straight from recovery, no idle clk.
              type_heavy_d = buf_heavy_m;
              buf_valid_d  = 1'b0;
              buf_heavy_d  = 1'b0;
              cnt_d        = buf_heavy_m ? HS_M1 : LS_M1;
              state_d      = S_STARTUP;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_STUN: begin
          if (frame_tick) begin
            if (cnt_zero) state_d = S_IDLE;
            else          cnt_d   = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      type_heavy_q <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_heavy_q  <= 1'b0;
      light_prev_q <= 1'b0;
      heavy_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      type_heavy_q <= type_heavy_d;
      buf_valid_q  <= buf_valid_d;
      buf_heavy_q  <= buf_heavy_d;
      light_prev_q <= btn_light;
      heavy_prev_q <= btn_heavy;
    end
  end

  assign attack_state = (state_q == S_ACTIVE) ? {type_heavy_q, ~type_heavy_q} : 2'b00;
  assign busy         = (state_q != S_IDLE);
  assign stunned      = (state_q == S_STUN);
  assign phase        = state_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// tb/tb_attack_sequencer.sv - self-checking bench for attack_sequencer.
module tb_attack_sequencer;

  localparam int LS = 3, LR = 8, HS = 6, HR = 16, STUN = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, btn_light, btn_heavy, hit_taken;
  logic [2:0] game_state;
  logic [1:0] attack_state;
  logic       busy, stunned;
  logic [2:0] phase;

  attack_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_light(btn_light), .btn_heavy(btn_heavy),
    .game_state(game_state), .hit_taken(hit_taken),
    .attack_state(attack_state), .busy(busy), .stunned(stunned), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: phase code, ticks remaining, buffer as 0 none / 1 light / 2 heavy.
  int m_phase, m_left, m_buf;
  bit m_heavy, m_pl, m_ph;

  typedef struct {
    logic l, h; logic [2:0] gs; logic hit, tk;
    logic [1:0] att; logic [2:0] ph;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic l, logic h, logic [2:0] gs, logic hit, logic tk,
                              logic [1:0] att, logic [2:0] ph);
    vec_t v;
    v.l = l; v.h = h; v.gs = gs; v.hit = hit; v.tk = tk; v.att = att; v.ph = ph;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_buf = 0; m_heavy = 0; m_pl = 0; m_ph = 0;
  endtask

  task automatic model_step(input logic l, input logic h, input logic [2:0] gs,
                            input logic hit, input logic tk);
    int pk;
    pk = (h && !m_ph) ? 2 : ((l && !m_pl) ? 1 : 0);
    if (gs != 0) begin
      m_phase = 0; m_left = 0; m_buf = 0;
    end else if (hit) begin
      m_phase = 4; m_left = STUN; m_buf = 0;
    end else begin
      case (m_phase)
        0: if (pk != 0) begin
             m_heavy = (pk == 2); m_phase = 1; m_left = m_heavy ? HS : LS;
           end
        1: begin
             if (pk > m_buf) m_buf = pk;
             if (tk) begin m_left--; if (m_left == 0) m_phase = 2; end
           end
        2: begin
             if (pk > m_buf) m_buf = pk;
             m_phase = 3; m_left = m_heavy ? HR : LR;
           end
        3: begin
             if (pk > m_buf) m_buf = pk;
             if (tk) begin
               m_left--;
               if (m_left == 0) begin
                 if (m_buf != 0) begin
                   m_heavy = (m_buf == 2); m_buf = 0; m_phase = 1; m_left = m_heavy ? HS : LS;
                 end else m_phase = 0;
               end
             end
           end
        default: if (tk) begin m_left--; if (m_left == 0) m_phase = 0; end
      endcase
    end
    m_pl = l; m_ph = h;
  endtask

  task automatic check_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    logic [6:0] exp, act;
    int ea;
    ea  = (m_phase == 2) ? (m_heavy ? 2 : 1) : 0;
    exp = {2'(ea), (m_phase != 0), (m_phase == 4), 3'(m_phase)};
    act = {attack_state, busy, stunned, phase};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model cyc=%0d got att=%0d busy=%0b stun=%0b ph=%0d want att=%0d busy=%0b stun=%0b ph=%0d",
               cyc, act[6:5], act[4], act[3], act[2:0], exp[6:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic drive(input logic l, input logic h, input logic [2:0] gs,
                       input logic hit, input logic tk);
    btn_light = l; btn_heavy = h; game_state = gs; hit_taken = hit; frame_tick = tk;
    @(posedge clk);
    model_step(l, h, gs, hit, tk);
    cyc++;
    #1;
  endtask

  task automatic cycle(input logic l, input logic h, input logic [2:0] gs,
                       input logic hit, input logic tk);
    drive(l, h, gs, hit, tk);
    compare_model();
  endtask

  function automatic logic tick4();
    return (cyc % 4) == 3;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    btn_light = 0; btn_heavy = 0; game_state = 0; hit_taken = 0; frame_tick = 0;
    @(posedge clk);
    #1;
    model_reset();
    check_eq("reset_outputs", int'({attack_state, busy, stunned, phase}), 0);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nstr, nlight, nheavy, first_b, last_b, nbusy, gap, a1, a2, sticks, found;
    bit rec_seen, hit2_done, was_st, hh, ll, l, h;
    logic [2:0] gs;
    int gs_hold;

    do_reset();

    // Scripted vectors: light attack, heavy buffered in recovery, fight stop, hit, stun ignore.
    tbl.push_back(mk(1, 0, 0, 0, 1, 2'd0, 3'd1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2'd0, 3'd1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2'd0, 3'd1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2'd1, 3'd2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'd0, 3'd3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'd0, 3'd3));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 2'd0, 3'd3));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2'd0, 3'd1));
    tbl.push_back(mk(0, 1, 3'd1, 0, 0, 2'd0, 3'd0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2'd0, 3'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'd0, 3'd1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 2'd0, 3'd4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0, 3'd4));
    foreach (tbl[i]) begin
      drive(tbl[i].l, tbl[i].h, tbl[i].gs, tbl[i].hit, tbl[i].tk);
      check_eq($sformatf("vec%0d_att", i), int'(attack_state), int'(tbl[i].att));
      check_eq($sformatf("vec%0d_ph", i), int'({busy, stunned, phase}),
               int'({(tbl[i].ph != 0), (tbl[i].ph == 4), tbl[i].ph}));
    end

    // Async reset mid-STARTUP.
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 check_eq("async_rst_outputs", int'({attack_state, busy, stunned, phase}), 0);
    model_reset();
    #2 reset = 1'b0;
    cycle(0, 0, 0, 0, 0);
    check_eq("after_rst_idle", int'(phase), 0);

    // Light attack with a tick every 4 clks: one strike, busy contiguous, back to idle.
    nlight = 0; first_b = -1; last_b = -1; nbusy = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(i < 2, 0, 0, 0, tick4());
      if (attack_state == 2'b01) nlight++;
      if (busy) begin
        if (first_b < 0) first_b = i;
        last_b = i; nbusy++;
      end
    end
    check_eq("light_strikes", nlight, 1);
    check_eq("light_busy_contig", nbusy, last_b - first_b + 1);
    check_eq("light_end_idle", int'(phase), 0);

    // Both buttons rise together and stay held: exactly one heavy strike.
    nlight = 0; nheavy = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1, 1, 0, 0, tick4());
      if (attack_state == 2'b10) nheavy++;
      if (attack_state == 2'b01) nlight++;
    end
    check_eq("both_heavy_strikes", nheavy, 1);
    check_eq("both_light_strikes", nlight, 0);

    // Heavy then light pressed in recovery: chained with no idle clk between.
    cycle(0, 0, 0, 0, tick4());
    nstr = 0; a1 = 0; a2 = 0; gap = 0; rec_seen = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(rec_seen, 1, 0, 0, tick4());
      if (phase == 3'd3) rec_seen = 1;
      if (attack_state != 0) begin
        if (nstr == 0) a1 = attack_state; else if (nstr == 1) a2 = attack_state;
        nstr++;
      end else if (nstr == 1 && !busy) gap++;
    end
    check_eq("chain_strikes", nstr, 2);
    check_eq("chain_first_type", a1, 2);
    check_eq("chain_second_type", a2, 1);
    check_eq("chain_idle_gap", gap, 0);

    // Hit on the ACTIVE clk, second hit after 5 stun ticks, press during stun ignored.
    cycle(0, 0, 0, 0, tick4());
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(0, 1, 0, 0, tick4());
      if (phase == 3'd2) found = 1;
    end
    check_eq("stun_active_found", found, 1);
    check_eq("stun_active_att", int'(attack_state), 2);
    cycle(0, 1, 0, 1, tick4());
    check_eq("stun_entered", int'(stunned), 1);
    sticks = 0; hit2_done = 0; nstr = 0;
    for (int i = 0; i < 300 && stunned; i++) begin
      bit tk, hit;
      tk = tick4();
      hit = !hit2_done && sticks == 5 && !tk;
      if (hit) hit2_done = 1;
      was_st = stunned;
      cycle(sticks >= 2, 1, 0, hit, tk);
      if (tk && !hit && was_st) sticks++;
      if (attack_state != 0) nstr++;
    end
    check_eq("stun_total_ticks", sticks, 15);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, 0, tick4());
      if (attack_state != 0) nstr++;
    end
    check_eq("stun_press_ignored", nstr, 0);
    check_eq("stun_end_idle", int'(phase), 0);

    // Fight ends during STARTUP; presses ignored while game_state != 0.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("gs_startup", int'(phase), 1);
    cycle(1, 0, 3'd1, 0, 1);
    check_eq("gs_idle_phase", int'(phase), 0);
    check_eq("gs_idle_att", int'(attack_state), 0);
    cycle(0, 0, 3'd1, 0, 1);
    cycle(1, 0, 3'd1, 0, 1);
    cycle(0, 1, 3'd1, 0, 1);
    check_eq("gs_press_ignored", int'(busy), 0);
    cycle(0, 1, 0, 0, 1);
    check_eq("gs_back_held_idle", int'(phase), 0);

    // Randomised run against the model.
    do_reset();
    ll = 0; hh = 0; gs = 0; gs_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) ll = ~ll;
      if ($urandom_range(0, 7) == 0) hh = ~hh;
      if (gs_hold > 0) gs_hold--;
      else if ($urandom_range(0, 199) == 0) begin
        gs_hold = $urandom_range(1, 6);
        gs = 3'($urandom_range(1, 7));
      end
      l = ll; h = hh;
      cycle(l, h, (gs_hold > 0) ? gs : 3'd0, $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
